serial_101_frame_packer: RTL and testbench
==========================================

# serial_101_frame_packer

Upstream feeder for the combinational 101-pattern counter. It accepts a bit-serial stream with a valid/ready handshake and packs each 32 bits into a frame word. It also counts `101` occurrences on the fly with a 3-state FSM, in overlapping or non-overlapping mode. The packed word, the latched mode and the streaming count are presented together through a one-deep valid/ready output, so downstream logic consumes the word and the count can be cross-checked against the combinational counter's `Y`.

## Interface
Parameters:
- `FRAME_W`, default 32: bits per frame. Fixed at 32 for this block; the count width below depends on it.

Ports:
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `bit_in`  in  1: serial data bit.
- `bit_valid`  in  1: `bit_in` is valid this cycle.
- `bit_ready`  out  1: block can accept a bit. A bit is accepted when `bit_valid & bit_ready`.
- `overlap`  in  1: mode select, sampled with the first bit of each frame (1 = overlapping, 0 = non-overlapping).
- `frame_data`  out  32: packed frame. The first bit received sits in bit 31, the last in bit 0.
- `frame_overlap`  out  1: mode latched for this frame.
- `frame_count`  out  4: number of `101` matches in the frame under `frame_overlap`.
- `frame_valid`  out  1: the output slot holds a frame.
- `frame_ready`  in  1: downstream accepts the frame. A transfer occurs when `frame_valid & frame_ready`.

## Operation
- **Shift stage:** `shreg[31:0]`, bit counter `bcnt[5:0]` (0..32), `mode_q`, `cnt_q[3:0]` and FSM state.
  - On each accepted bit: `shreg <= {shreg[30:0], bit_in}` and `bcnt++`.
  - When `bcnt == 0`, `mode_q <= overlap`. The `overlap` value on any other cycle is ignored.
- **FSM states:** `S_IDLE` (no prefix), `S_1` (seen `1`), `S_10` (seen `10`). Transitions on an accepted bit:
  - `S_IDLE`: 1 -> `S_1`; 0 -> `S_IDLE`.
  - `S_1`: 1 -> `S_1`; 0 -> `S_10`.
  - `S_10`: 1 -> match, `cnt_q++`, next state = `mode_q ? S_1 : S_IDLE`; 0 -> `S_IDLE`.
- **Frame boundary:** no match spans two frames. At frame start the FSM is in `S_IDLE` and `cnt_q = 0`.
  - For the first bit of a frame, the match and next-state logic use the incoming `overlap` value, not the stale `mode_q`.
- **Count width:** `cnt_q` never exceeds 15, which is reached by the overlap case 0xAAAAAAAA. The non-overlap maximum is 10. No saturation logic is required. Verification must flag any value above 15 as an error.
- **Frame completion:** when the 32nd bit is accepted, the frame is complete, with the count including that bit's match.
  - If the output slot is empty, or is being drained this same cycle, the frame moves to the output slot. `shreg` restarts with `bcnt = 0`, state `S_IDLE` and `cnt_q = 0`.
  - Otherwise the block enters the held condition: `bcnt == 32`, `bit_ready = 0`. The shift stage holds the frame until the slot frees, then transfers it and restarts.
- **Output slot:** `frame_data`, `frame_overlap` and `frame_count` are stable while `frame_valid = 1 & frame_ready = 0`.
  - `frame_valid` clears on transfer unless a new frame loads in the same cycle.
- `bit_ready = (bcnt != 32)`. It is a registered-state decode and does not depend combinationally on `frame_ready`.
- **Reset:** asynchronous clear of all state.
  - Outputs: `frame_valid = 0`, `frame_data = 0`, `frame_count = 0`, `frame_overlap = 0`, `bit_ready = 1` as soon as `rst_n` deasserts.
  - A partial frame at reset is discarded.

## Timing
- **Latency:** the 32nd bit is accepted at edge N, and `frame_valid = 1` with the final data and count is visible after edge N, i.e. in cycle N+1. This is a 1-cycle registered transfer.
- **Throughput:** one bit per cycle with `frame_ready` held at 1. Frames are back-to-back with no bubble: the first bit of the next frame is accepted the cycle after the 32nd bit.
- **Simultaneous events:** a slot drain and a new-frame load on the same edge leave `frame_valid = 1` with the new frame.
- **Held condition:** a held frame loads on the edge where the slot drains. `bit_ready` returns to 1 in the following cycle.
- `bit_valid = 0` cycles do not advance the FSM or the count.

## Test plan
- **Overlap, alternating pattern:** overlap=1, stream 0xAAAAAAAA MSB-first, `frame_ready = 1` -> `frame_data = 0xAAAAAAAA`, `frame_count = 15`, `frame_overlap = 1`, one cycle after the last bit.
- **Non-overlap and mode latching:** overlap=0, stream 0xAAAAAAAA -> `frame_count = 8`. Then stream 0xB6DB6DB6 with overlap=0 and again with overlap=1 -> `count = 10` in both. Toggling `overlap` mid-frame must not change the result.
- **Backpressure:** hold `frame_ready = 0` and stream 64 bits (0xFFFFFFFF then 0x00000000).
  - Expect `bit_ready` low after the 64th bit, and `frame_data = 0xFFFFFFFF` with `count = 0` stable.
  - Raise `frame_ready` for one cycle -> the slot shows 0x00000000 with `count = 0` the next cycle, and `bit_ready = 1`.
- **Frame boundary isolation:** frame 1 ends in `...10`, frame 2 starts with `1...` -> no cross-frame match. Frame 1 = 0x00000002 -> `count = 0`; frame 2 = 0x80000000 -> `count = 0`.
- **Reset mid-frame and gapped input:**
  - Pull `rst_n` low after 17 bits -> immediately `frame_valid = 0` and `bit_ready = 1`. The next full 32-bit frame is counted from scratch, e.g. 0x00000005 -> `count = 1`.
  - Random `bit_valid` gaps -> identical results.
- **Random frames:** 20 random frames, each with a random mode. `frame_count` must equal the reference count for that word and mode. Frames with a random `frame_ready` duty cycle must be neither lost nor duplicated.

Source files
------------

// File: rtl/serial_101_frame_packer.sv
// Bit-serial to 32-bit frame packer with an on-the-fly "101" match counter.
// Each packed word, its latched mode and its match count leave through a one-deep valid/ready slot.
module serial_101_frame_packer #(
  parameter int FRAME_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               bit_in,
  input  logic               bit_valid,
  output logic               bit_ready,
  input  logic               overlap,
  output logic [FRAME_W-1:0] frame_data,
  output logic               frame_overlap,
  output logic [3:0]         frame_count,
  output logic               frame_valid,
  input  logic               frame_ready
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_1    = 2'd1,
    S_10   = 2'd2
  } state_t;

  localparam logic [5:0] LAST_BIT = 6'(FRAME_W - 1);
  localparam logic [5:0] FULL     = 6'(FRAME_W);

  state_t               state_r, state_nxt_s, step_state_s;
  logic [FRAME_W-1:0]   shreg_r, shreg_nxt_s, shift_s;
  logic [5:0]           bcnt_r, bcnt_nxt_s;
  logic                 mode_r, mode_nxt_s, eff_mode_s;
  logic [3:0]           cnt_r, cnt_nxt_s, cnt_inc_s;
  logic                 bit_ready_r, bit_ready_nxt_s;
  logic [FRAME_W-1:0]   slot_data_r, slot_data_nxt_s;
  logic                 slot_ovl_r, slot_ovl_nxt_s;
  logic [3:0]           slot_cnt_r, slot_cnt_nxt_s;
  logic                 slot_valid_r, slot_valid_nxt_s;
  logic                 accept_s, match_s, complete_s, held_s, slot_free_s, load_s;

  // Next-state logic for the match FSM, shift stage and output slot.
  always_comb begin
    accept_s     = bit_valid & bit_ready_r;
    // The first bit of a frame must see the incoming mode, not last frame's.
    eff_mode_s   = (bcnt_r == 6'd0) ? overlap : mode_r;
    step_state_s = S_IDLE;
    match_s      = 1'b0;
    case (state_r)
      S_IDLE: step_state_s = bit_in ? S_1 : S_IDLE;
      S_1:    step_state_s = bit_in ? S_1 : S_10;
      S_10: begin
        if (bit_in) begin
          match_s      = 1'b1;
          step_state_s = eff_mode_s ? S_1 : S_IDLE;
        end else begin
          step_state_s = S_IDLE;
        end
      end
      default: step_state_s = S_IDLE;
    endcase

    shift_s     = {shreg_r[FRAME_W-2:0], bit_in};
    cnt_inc_s   = cnt_r + {3'd0, match_s};
    complete_s  = accept_s && (bcnt_r == LAST_BIT);
    held_s      = (bcnt_r == FULL);
    slot_free_s = !slot_valid_r || frame_ready;
    load_s      = (complete_s || held_s) && slot_free_s;

    state_nxt_s      = state_r;
    shreg_nxt_s      = shreg_r;
    bcnt_nxt_s       = bcnt_r;
    mode_nxt_s       = mode_r;
    cnt_nxt_s        = cnt_r;
    slot_data_nxt_s  = slot_data_r;
    slot_ovl_nxt_s   = slot_ovl_r;
    slot_cnt_nxt_s   = slot_cnt_r;
    slot_valid_nxt_s = slot_valid_r;

    if (load_s) begin
      state_nxt_s = S_IDLE;
      shreg_nxt_s = '0;
      bcnt_nxt_s  = 6'd0;
      cnt_nxt_s   = 4'd0;
      mode_nxt_s  = mode_r;
    end else if (accept_s) begin
      state_nxt_s = step_state_s;
      shreg_nxt_s = shift_s;
      bcnt_nxt_s  = bcnt_r + 6'd1;
      cnt_nxt_s   = cnt_inc_s;
      mode_nxt_s  = eff_mode_s;
    end else begin
      state_nxt_s = state_r;
    end

    // A held frame already sits in the shift stage; a completing one is still in flight.
    if (load_s) begin
      slot_data_nxt_s  = held_s ? shreg_r : shift_s;
      slot_ovl_nxt_s   = held_s ? mode_r  : eff_mode_s;
      slot_cnt_nxt_s   = held_s ? cnt_r   : cnt_inc_s;
      slot_valid_nxt_s = 1'b1;
    end else if (slot_valid_r && frame_ready) begin
      slot_valid_nxt_s = 1'b0;
    end else begin
      slot_valid_nxt_s = slot_valid_r;
    end

    bit_ready_nxt_s = (bcnt_nxt_s != FULL);
  end

  // State register for the shift stage, FSM and output slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= S_IDLE;
      shreg_r      <= '0;
      bcnt_r       <= 6'd0;
      mode_r       <= 1'b0;
      cnt_r        <= 4'd0;
      bit_ready_r  <= 1'b1;
      slot_data_r  <= '0;
      slot_ovl_r   <= 1'b0;
      slot_cnt_r   <= 4'd0;
      slot_valid_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      shreg_r      <= shreg_nxt_s;
      bcnt_r       <= bcnt_nxt_s;
      mode_r       <= mode_nxt_s;
      cnt_r        <= cnt_nxt_s;
      bit_ready_r  <= bit_ready_nxt_s;
      slot_data_r  <= slot_data_nxt_s;
      slot_ovl_r   <= slot_ovl_nxt_s;
      slot_cnt_r   <= slot_cnt_nxt_s;
      slot_valid_r <= slot_valid_nxt_s;
    end
  end

  assign bit_ready     = bit_ready_r;
  assign frame_data    = slot_data_r;
  assign frame_overlap = slot_ovl_r;
  assign frame_count   = slot_cnt_r;
  assign frame_valid   = slot_valid_r;

endmodule

// File: tb/tb_serial_101_frame_packer.sv
// Self-checking bench for serial_101_frame_packer: vector table, corner-case sequences,
// and a scoreboard queue popped on every output transfer.
module tb_serial_101_frame_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bit_in;
  logic        bit_valid;
  logic        bit_ready;
  logic        overlap;
  logic [31:0] frame_data;
  logic        frame_overlap;
  logic [3:0]  frame_count;
  logic        frame_valid;
  logic        frame_ready;

  typedef struct {
    logic [31:0] data;
    logic        ovl;
    logic [3:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t tbl[7];
  int   n_vec = 0;
  int   n_err = 0;
  bit   rand_ready = 1'b0;
  bit   last_acc = 1'b0;

  always #5 clk = ~clk;

  serial_101_frame_packer #(.FRAME_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bit_in       (bit_in),
    .bit_valid    (bit_valid),
    .bit_ready    (bit_ready),
    .overlap      (overlap),
    .frame_data   (frame_data),
    .frame_overlap(frame_overlap),
    .frame_count  (frame_count),
    .frame_valid  (frame_valid),
    .frame_ready  (frame_ready)
  );

  // Reference "101" counter, MSB first; non-overlap skips the whole match.
  function automatic int ref_count(logic [31:0] w, logic ov);
    int i;
    int c;
    i = 31;
    c = 0;
    while (i >= 2) begin
      if (w[i] && !w[i-1] && w[i-2]) begin
        c++;
        i = ov ? i - 2 : i - 3;
      end else begin
        i--;
      end
    end
    return c;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // One clock: observe at negedge (acceptance and output transfers), then step past posedge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    last_acc = bit_valid & bit_ready;
    if (rst_n && frame_valid && frame_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_frame: got frame 0x%0h, want none", frame_data);
      end else begin
        e = exp_q.pop_front();
        check("out_data", frame_data, e.data);
        check("out_overlap", 32'(frame_overlap), 32'(e.ovl));
        check("out_count", 32'(frame_count), 32'(e.cnt));
      end
    end
    @(posedge clk);
    #1;
    if (rand_ready) frame_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_bit(logic b, logic ov, bit gaps);
    int budget;
    bit_valid = 1'b1;
    bit_in    = b;
    overlap   = ov;
    budget    = 0;
    do begin
      tick();
      budget++;
    end while (!last_acc && budget < 200);
    if (!last_acc) begin
      n_vec++;
      n_err++;
      $display("FAIL bit_accept_timeout: bit_ready=%0b, want 1", bit_ready);
    end
    if (gaps && $urandom_range(0, 2) == 0) begin
      bit_valid = 1'b0;
      bit_in    = 1'($urandom);
      overlap   = 1'($urandom);
      repeat ($urandom_range(1, 3)) tick();
    end
  endtask

  // Overlap is driven opposite to the frame mode after the first bit to prove it is latched.
  task automatic send_frame(logic [31:0] word, logic ov, logic [3:0] cnt, bit push, bit gaps);
    if (push) exp_q.push_back('{data: word, ovl: ov, cnt: cnt});
    for (int i = 31; i >= 0; i--) send_bit(word[i], (i == 31) ? ov : ~ov, gaps);
    bit_valid = 1'b0;
  endtask

  task automatic drain();
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < 400) begin
      tick();
      b++;
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    logic        ov;

    tbl[0] = '{data: 32'hAAAA_AAAA, ovl: 1'b1, cnt: 4'd15};
    tbl[1] = '{data: 32'hAAAA_AAAA, ovl: 1'b0, cnt: 4'd8};
    tbl[2] = '{data: 32'hB6DB_6DB6, ovl: 1'b0, cnt: 4'd10};
    tbl[3] = '{data: 32'hB6DB_6DB6, ovl: 1'b1, cnt: 4'd10};
    tbl[4] = '{data: 32'h0000_0002, ovl: 1'b1, cnt: 4'd0};
    tbl[5] = '{data: 32'h8000_0000, ovl: 1'b1, cnt: 4'd0};
    tbl[6] = '{data: 32'h0000_0005, ovl: 1'b0, cnt: 4'd1};

    rst_n       = 1'b0;
    bit_in      = 1'b0;
    bit_valid   = 1'b0;
    overlap     = 1'b0;
    frame_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_frame_valid", 32'(frame_valid), 32'd0);
    check("rst_bit_ready", 32'(bit_ready), 32'd1);
    check("rst_frame_data", frame_data, 32'd0);
    check("rst_frame_count", 32'(frame_count), 32'd0);
    check("rst_frame_overlap", 32'(frame_overlap), 32'd0);
    rst_n = 1'b1;
    tick();
    check("post_rst_bit_ready", 32'(bit_ready), 32'd1);

    // Back-to-back frames from the table, with the 1-cycle latency checked after each last bit.
    for (int i = 0; i < 7; i++) begin
      send_frame(tbl[i].data, tbl[i].ovl, tbl[i].cnt, 1'b1, 1'b0);
      check("lat_valid", 32'(frame_valid), 32'd1);
      check("lat_data", frame_data, tbl[i].data);
      check("lat_count", 32'(frame_count), 32'(tbl[i].cnt));
      check("lat_overlap", 32'(frame_overlap), 32'(tbl[i].ovl));
    end
    drain();

    // Backpressure: second frame must wait in the shift stage.
    frame_ready = 1'b0;
    send_frame(32'hFFFF_FFFF, 1'b0, 4'd0, 1'b1, 1'b0);
    send_frame(32'h0000_0000, 1'b0, 4'd0, 1'b1, 1'b0);
    check("bp_bit_ready_low", 32'(bit_ready), 32'd0);
    check("bp_valid", 32'(frame_valid), 32'd1);
    check("bp_data", frame_data, 32'hFFFF_FFFF);
    check("bp_count", 32'(frame_count), 32'd0);
    repeat (3) tick();
    check("bp_data_stable", frame_data, 32'hFFFF_FFFF);
    check("bp_bit_ready_still_low", 32'(bit_ready), 32'd0);
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    check("bp_reload_valid", 32'(frame_valid), 32'd1);
    check("bp_reload_data", frame_data, 32'h0000_0000);
    check("bp_reload_count", 32'(frame_count), 32'd0);
    check("bp_bit_ready_back", 32'(bit_ready), 32'd1);
    frame_ready = 1'b1;
    drain();

    // Reset with a full slot and a 17-bit partial frame: both are discarded.
    frame_ready = 1'b0;
    send_frame(32'h1234_5678, 1'b1, 4'd0, 1'b0, 1'b0);
    w = 32'hFFFF_8000;
    for (int i = 31; i >= 15; i--) send_bit(w[i], 1'b1, 1'b0);
    bit_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(frame_valid), 32'd0);
    check("midrst_bit_ready", 32'(bit_ready), 32'd1);
    check("midrst_data", frame_data, 32'd0);
    check("midrst_count", 32'(frame_count), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    frame_ready = 1'b1;
    send_frame(32'h0000_0005, 1'b0, 4'd1, 1'b1, 1'b1);
    drain();

    // Random words and modes with input gaps and a random output-ready duty cycle.
    rand_ready = 1'b1;
    for (int f = 0; f < 20; f++) begin
      w  = $urandom;
      ov = 1'($urandom_range(0, 1));
      send_frame(w, ov, 4'(ref_count(w, ov)), 1'b1, 1'b1);
    end
    rand_ready  = 1'b0;
    frame_ready = 1'b1;
    drain();
    repeat (2) tick();
    check("idle_after_drain", 32'(frame_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
